tdm_demux4: RTL and testbench

- Receive end of the 4:1 channel-multiplexing path.
- Takes one time-division-multiplexed stream, where each frame carries slots 0..3 in order and slot 0 is marked by frame_sync.
- Rebuilds the four channels and presents them together as one frame on a registered parallel bus.
- Sits after the serial link; feeds per-channel consumers.

---
 rtl/tdm_pkg.sv | 33 +++
 rtl/tdm_slot_ctr.sv | 46 ++++
 rtl/tdm_demux4.sv | 119 +++++++++++
 tb/tb_tdm_demux4.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM mux/demux path: slot geometry, FSM states,
// counter operation codes and the slot one-hot decode used by both link ends.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SLOT_HOLD,
    SLOT_ADV,
    SLOT_LOAD1,
    SLOT_CLR
  } slot_op_t;

  typedef enum logic [1:0] {
    MISS_HOLD,
    MISS_INC,
    MISS_CLR
  } miss_op_t;

  function automatic logic [NUM_SLOTS-1:0] onehot(input logic [SLOT_W-1:0] slot);
    logic [NUM_SLOTS-1:0] r;
    r       = '0;
    r[slot] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter plus the consecutive-unmarked-frame (miss) counter.
// miss_hit tells the FSM that one more increment would reach MISS_LIMIT.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int MISS_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  slot_op_t          slot_op,
  input  miss_op_t          miss_op,
  output logic [SLOT_W-1:0] slot,
  output logic              miss_hit
);

  logic [1:0] miss;

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else begin
      case (slot_op)
        SLOT_ADV:   slot <= slot + 1'b1;
        SLOT_LOAD1: slot <= SLOT_W'(1);
        SLOT_CLR:   slot <= '0;
        default:    slot <= slot;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss <= '0;
    end else begin
      case (miss_op)
        MISS_INC: miss <= miss + 1'b1;
        MISS_CLR: miss <= '0;
        default:  miss <= miss;
      endcase
    end
  end

  assign miss_hit = ({1'b0, miss} + 3'd1) >= 3'(MISS_LIMIT);

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link: locks onto frame_sync, collects slots 0..3 into a
// shadow register and publishes each complete frame on dout in a single update.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int MISS_LIMIT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  input  logic                       frame_sync,
  output logic [NUM_SLOTS*WIDTH-1:0] dout,
  output logic                       frame_valid,
  output logic [NUM_SLOTS-1:0]       ch_strobe,
  output logic                       locked,
  output logic                       sync_err
);

  state_t                             state_q, state_d;
  logic [NUM_SLOTS-1:0][WIDTH-1:0]    shadow_q, shadow_d;
  logic [NUM_SLOTS*WIDTH-1:0]         dout_d;
  logic                               frame_valid_d;
  logic [NUM_SLOTS-1:0]               ch_strobe_d;
  logic                               sync_err_d;
  slot_op_t                           slot_op;
  miss_op_t                           miss_op;
  logic [SLOT_W-1:0]                  slot;
  logic                               miss_hit;

  tdm_slot_ctr #(
    .MISS_LIMIT(MISS_LIMIT)
  ) u_slot_ctr (
    .clk      (clk),
    .rst      (rst),
    .slot_op  (slot_op),
    .miss_op  (miss_op),
    .slot     (slot),
    .miss_hit (miss_hit)
  );

  // NOTE: every variable gets a default first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    dout_d        = dout;
    frame_valid_d = 1'b0;
    ch_strobe_d   = '0;
    sync_err_d    = 1'b0;
    slot_op       = SLOT_HOLD;
    miss_op       = MISS_HOLD;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            shadow_d[0] = din;
            ch_strobe_d = onehot(SLOT_W'(0));
            slot_op     = SLOT_LOAD1;
            miss_op     = MISS_CLR;
            state_d     = LOCKED;
          end
        end

        LOCKED: begin
          if (frame_sync && slot != '0) begin
            // Misaligned marker: abandon the partial frame and restart it at this slot.
            sync_err_d  = 1'b1;
            shadow_d[0] = din;
            ch_strobe_d = onehot(SLOT_W'(0));
            slot_op     = SLOT_LOAD1;
            miss_op     = MISS_CLR;
          end else if (!frame_sync && slot == '0 && miss_hit) begin
            sync_err_d  = 1'b1;
            slot_op     = SLOT_CLR;
            miss_op     = MISS_CLR;
            state_d     = HUNT;
          end else begin
            shadow_d[slot] = din;
            ch_strobe_d    = onehot(slot);
            slot_op        = SLOT_ADV;
            if (slot == '0) begin
              miss_op = frame_sync ? MISS_CLR : MISS_INC;
            end
            if (slot == SLOT_W'(NUM_SLOTS - 1)) begin
              dout_d        = shadow_d;
              frame_valid_d = 1'b1;
            end
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: shadow is a small register bank, not a RAM, so it is reset along with the rest of the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      shadow_q    <= '0;
      dout        <= '0;
      frame_valid <= 1'b0;
      ch_strobe   <= '0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      dout        <= dout_d;
      frame_valid <= frame_valid_d;
      ch_strobe   <= ch_strobe_d;
      locked      <= (state_d == LOCKED);
      sync_err    <= sync_err_d;
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (WIDTH=4, MISS_LIMIT=2): per-scenario tasks check the
// per-slot outputs inline while a scoreboard queue holds the frames expected on dout.
module tb_tdm_demux4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        frame_sync = 1'b0;
  logic [15:0] dout;
  logic        frame_valid;
  logic [3:0]  ch_strobe;
  logic        locked;
  logic        sync_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [15:0] sb[$];

  tdm_demux4 #(
    .WIDTH      (4),
    .MISS_LIMIT (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .dout        (dout),
    .frame_valid (frame_valid),
    .ch_strobe   (ch_strobe),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every published frame must match the oldest expected one.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL frame_unexpected dout=%h (no frame expected)", dout);
      end else begin
        logic [15:0] exp;
        exp = sb.pop_front();
        if (dout !== exp) begin
          n_bad++;
          $display("FAIL frame_data dout=%h expected=%h", dout, exp);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] d, input logic v, input logic fs);
    @(negedge clk);
    din        = d;
    din_valid  = v;
    frame_sync = fs;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({dout, frame_valid, ch_strobe, locked, sync_err} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_outputs dout=%h fv=%b strobe=%b locked=%b err=%b expected all zero",
               dout, frame_valid, ch_strobe, locked, sync_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock_frame();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb.push_back(16'h8421);
      drive(4'b0001 << i, 1'b1, i == 0);
      n_cmp++;
      if (ch_strobe !== (4'b0001 << i) || locked !== 1'b1 || frame_valid !== (i == 3)
          || sync_err !== 1'b0) begin
        n_bad++;
        $display("FAIL lock_slot%0d strobe=%b locked=%b fv=%b err=%b expected strobe=%b locked=1 fv=%b err=0",
                 i, ch_strobe, locked, frame_valid, sync_err, 4'b0001 << i, i == 3);
      end
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb.push_back(16'h8421);
      drive(4'b0001 << i, 1'b1, i == 0);
      n_cmp++;
      if (ch_strobe !== (4'b0001 << i) || frame_valid !== (i == 3)) begin
        n_bad++;
        $display("FAIL gap_slot%0d strobe=%b fv=%b expected strobe=%b fv=%b",
                 i, ch_strobe, frame_valid, 4'b0001 << i, i == 3);
      end
      drive(4'hF, 1'b0, 1'b1);
      n_cmp++;
      if (ch_strobe !== 4'b0000 || frame_valid !== 1'b0 || sync_err !== 1'b0) begin
        n_bad++;
        $display("FAIL gap_idle%0d strobe=%b fv=%b err=%b expected 0000/0/0",
                 i, ch_strobe, frame_valid, sync_err);
      end
    end
  endtask

  task automatic test_misalign();
    logic [3:0] vals[6];
    logic [3:0] exp_strobe[6];
    logic       fs_in[6];
    vals       = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    exp_strobe = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    fs_in      = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      if (i == 5) sb.push_back(16'hFEDC);
      drive(vals[i], 1'b1, fs_in[i]);
      n_cmp++;
      if (ch_strobe !== exp_strobe[i] || sync_err !== (i == 2) || frame_valid !== (i == 5)
          || locked !== 1'b1) begin
        n_bad++;
        $display("FAIL misalign_step%0d strobe=%b err=%b fv=%b locked=%b expected strobe=%b err=%b fv=%b locked=1",
                 i, ch_strobe, sync_err, frame_valid, locked, exp_strobe[i], i == 2, i == 5);
      end
    end
  endtask

  task automatic test_loss_of_lock();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 3) sb.push_back(f == 0 ? 16'h4321 : 16'h8765);
        drive(4'(f * 4 + i + 1), 1'b1, f == 0 && i == 0);
        n_cmp++;
        if (ch_strobe !== (4'b0001 << i) || sync_err !== 1'b0 || frame_valid !== (i == 3)
            || locked !== 1'b1) begin
          n_bad++;
          $display("FAIL loss_f%0d_slot%0d strobe=%b err=%b fv=%b locked=%b expected strobe=%b err=0 fv=%b locked=1",
                   f, i, ch_strobe, sync_err, frame_valid, locked, 4'b0001 << i, i == 3);
        end
      end
    end
    drive(4'h9, 1'b1, 1'b0);
    n_cmp++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || ch_strobe !== 4'b0000 || frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL loss_drop err=%b locked=%b strobe=%b fv=%b expected err=1 locked=0 strobe=0000 fv=0",
               sync_err, locked, ch_strobe, frame_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(4'(i + 10), 1'b1, 1'b0);
      n_cmp++;
      if (ch_strobe !== 4'b0000 || sync_err !== 1'b0 || locked !== 1'b0) begin
        n_bad++;
        $display("FAIL loss_hunt%0d strobe=%b err=%b locked=%b expected 0000/0/0",
                 i, ch_strobe, sync_err, locked);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(4'h5, 1'b1, 1'b1);
    drive(4'h6, 1'b1, 1'b0);
    n_cmp++;
    if (ch_strobe !== 4'b0010 || locked !== 1'b1 || dout !== 16'h8765) begin
      n_bad++;
      $display("FAIL midrst_before strobe=%b locked=%b dout=%h expected 0010/1/8765",
               ch_strobe, locked, dout);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({dout, frame_valid, ch_strobe, locked, sync_err} !== 23'd0) begin
      n_bad++;
      $display("FAIL midrst_async dout=%h fv=%b strobe=%b locked=%b err=%b expected all zero",
               dout, frame_valid, ch_strobe, locked, sync_err);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb.push_back(16'h3333);
      drive(4'h3, 1'b1, i == 0);
      n_cmp++;
      if (ch_strobe !== (4'b0001 << i) || frame_valid !== (i == 3) || locked !== 1'b1) begin
        n_bad++;
        $display("FAIL midrst_frame_slot%0d strobe=%b fv=%b locked=%b expected strobe=%b fv=%b locked=1",
                 i, ch_strobe, frame_valid, locked, 4'b0001 << i, i == 3);
      end
    end
  endtask

  task automatic test_hunt_filter();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'(i + 1), 1'b1, 1'b0);
      n_cmp++;
      if (ch_strobe !== 4'b0000 || frame_valid !== 1'b0 || locked !== 1'b0 || dout !== 16'h0000) begin
        n_bad++;
        $display("FAIL hunt_slot%0d strobe=%b fv=%b locked=%b dout=%h expected 0000/0/0/0000",
                 i, ch_strobe, frame_valid, locked, dout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_frame();
    test_gaps();
    test_misalign();
    test_loss_of_lock();
    test_mid_reset();
    test_hunt_filter();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL frames_missing pending=%0d expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
